// File: rtl/ccdiv_seq.sv
// ccdiv_seq: sequential signed fixed-point complex divider, q = a / b.
//
// The result is formed as a*conj(b) / |b|^2. The two numerator parts and the
// denominator are built from full-width products. Each quotient part is then
// produced by its own restoring divider, and the two dividers run side by side
// at one quotient bit per cycle. Results truncate toward zero and saturate to
// the signed TOTAL_WIDTH range.
//
// Ports:
//   clk        clock, rising edge active
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block idle and able to accept operands (registered)
//   ar, ai     dividend real / imaginary (signed, TOTAL_WIDTH)
//   br, bi     divisor real / imaginary (signed, TOTAL_WIDTH)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   qr, qi     quotient real / imaginary (signed, TOTAL_WIDTH)
//   div_zero   divisor was 0+0i (qualified by out_valid)
module ccdiv_seq #(
    parameter int TOTAL_WIDTH = 16,
    parameter int FRAC_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [TOTAL_WIDTH-1:0] ar,
    input  logic signed [TOTAL_WIDTH-1:0] ai,
    input  logic signed [TOTAL_WIDTH-1:0] br,
    input  logic signed [TOTAL_WIDTH-1:0] bi,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [TOTAL_WIDTH-1:0] qr,
    output logic signed [TOTAL_WIDTH-1:0] qi,
    output logic                          div_zero
);

    localparam int W    = TOTAL_WIDTH;
    localparam int F    = FRAC_WIDTH;
    localparam int PW   = 2 * W;          // full product width
    localparam int SW   = 2 * W + 1;      // sum width with guard bit
    localparam int NW   = 2 * W + F;      // scaled numerator magnitude width
    localparam int CW   = 3 * W + F + 2;  // overflow pre-check compare width
    localparam int QW   = W + 1;          // quotient bits produced by the divider
    localparam int CNTW = $clog2(W + 2);

    localparam logic [QW-1:0] POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [QW-1:0] NEG_LIM = {2'b01, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t                 state;
    logic signed [W-1:0]    a_re, a_im, b_re, b_im;
    logic [PW-1:0]          rem_re, rem_im;
    logic [QW-1:0]          lo_re, lo_im;
    logic [QW-1:0]          quo_re, quo_im;
    logic [SW-1:0]          den;
    logic                   neg_re, neg_im;
    logic                   ovf_re, ovf_im;
    logic                   dz;
    logic [CNTW-1:0]        cnt;

    // Product and numerator formation from the captured operands.
    // Operands are sign-extended to product width first, so -2^(W-1)
    // squares and negates without wrapping.
    logic signed [PW-1:0]   p_rr, p_ii, p_ir, p_ri, p_bbr, p_bbi;
    logic signed [SW-1:0]   nr_c, ni_c;
    logic [SW-1:0]          den_c;
    logic [PW-1:0]          abs_nr, abs_ni;
    logic [NW-1:0]          num_re, num_im;
    logic                   ovf_re_c, ovf_im_c;

    assign p_rr  = PW'(a_re) * PW'(b_re);
    assign p_ii  = PW'(a_im) * PW'(b_im);
    assign p_ir  = PW'(a_im) * PW'(b_re);
    assign p_ri  = PW'(a_re) * PW'(b_im);
    assign p_bbr = PW'(b_re) * PW'(b_re);
    assign p_bbi = PW'(b_im) * PW'(b_im);

    assign nr_c  = SW'(p_rr) + SW'(p_ii);
    assign ni_c  = SW'(p_ir) - SW'(p_ri);
    assign den_c = SW'(p_bbr) + SW'(p_bbi);

    assign abs_nr = PW'(nr_c[SW-1] ? -nr_c : nr_c);
    assign abs_ni = PW'(ni_c[SW-1] ? -ni_c : ni_c);

    assign num_re = NW'(abs_nr) << F;
    assign num_im = NW'(abs_ni) << F;

    // If the scaled numerator reaches den * 2^(W+1), the quotient does not fit
    // in the W+1 bits the divider produces and the part saturates anyway.
    // Otherwise the top bits of the numerator are already below den and can
    // seed the partial remainder directly.
    assign ovf_re_c = CW'(num_re) >= (CW'(den_c) << (W + 1));
    assign ovf_im_c = CW'(num_im) >= (CW'(den_c) << (W + 1));

    // One restoring step per part: shift in the next numerator bit and
    // subtract the denominator when it fits.
    logic [SW-1:0]          rem2_re, rem2_im, rem_nx_re, rem_nx_im;
    logic                   ge_re, ge_im;

    always_comb begin
        rem2_re   = {rem_re, lo_re[QW-1]};
        rem2_im   = {rem_im, lo_im[QW-1]};
        ge_re     = rem2_re >= den;
        ge_im     = rem2_im >= den;
        rem_nx_re = rem2_re;
        rem_nx_im = rem2_im;
        if (ge_re) begin
            rem_nx_re = rem2_re - den;
        end
        if (ge_im) begin
            rem_nx_im = rem2_im - den;
        end
    end

    // Apply the sign to the unsigned quotient and clamp to the W-bit range.
    function automatic logic [W-1:0] saturate(input logic neg, input logic ovf,
                                              input logic [QW-1:0] q);
        logic [W-1:0] q_low;
        logic [W-1:0] r;
        q_low = q[W-1:0];
        if (!neg) begin
            r = (ovf || q >= POS_LIM) ? MAX_VAL : q_low;
        end else begin
            r = (ovf || q >= NEG_LIM) ? MIN_VAL : -q_low;
        end
        return r;
    endfunction

    // Control FSM and datapath registers. DONE spends its first cycle
    // loading the registered outputs, then holds them until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            qr        <= '0;
            qi        <= '0;
            div_zero  <= 1'b0;
            a_re      <= '0;
            a_im      <= '0;
            b_re      <= '0;
            b_im      <= '0;
            rem_re    <= '0;
            rem_im    <= '0;
            lo_re     <= '0;
            lo_im     <= '0;
            quo_re    <= '0;
            quo_im    <= '0;
            den       <= '0;
            neg_re    <= 1'b0;
            neg_im    <= 1'b0;
            ovf_re    <= 1'b0;
            ovf_im    <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_re     <= ar;
                        a_im     <= ai;
                        b_re     <= br;
                        b_im     <= bi;
                        in_ready <= 1'b0;
                        state    <= MULT;
                    end
                end
                MULT: begin
                    rem_re <= PW'(num_re >> (W + 1));
                    rem_im <= PW'(num_im >> (W + 1));
                    lo_re  <= num_re[QW-1:0];
                    lo_im  <= num_im[QW-1:0];
                    quo_re <= '0;
                    quo_im <= '0;
                    den    <= den_c;
                    neg_re <= nr_c[SW-1];
                    neg_im <= ni_c[SW-1];
                    ovf_re <= ovf_re_c;
                    ovf_im <= ovf_im_c;
                    cnt    <= '0;
                    if (den_c == '0) begin
                        dz    <= 1'b1;
                        state <= DONE;
                    end else begin
                        dz    <= 1'b0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem_re <= PW'(rem_nx_re);
                    rem_im <= PW'(rem_nx_im);
                    lo_re  <= {lo_re[QW-2:0], 1'b0};
                    lo_im  <= {lo_im[QW-2:0], 1'b0};
                    quo_re <= {quo_re[QW-2:0], ge_re};
                    quo_im <= {quo_im[QW-2:0], ge_im};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNTW'(W)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        div_zero  <= dz;
                        qr        <= dz ? '0 : saturate(neg_re, ovf_re, quo_re);
                        qi        <= dz ? '0 : saturate(neg_im, ovf_im, quo_im);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccdiv_seq.sv
// tb_ccdiv_seq: self-checking bench for ccdiv_seq (TOTAL_WIDTH=16, FRAC_WIDTH=8).
// A driver process applies directed and random operand sets. A single monitor
// process predicts every result arithmetically and checks the DUT each cycle.
module tb_ccdiv_seq;

    localparam int     W     = 16;
    localparam int     F     = 8;
    localparam longint MAXV  = 32767;
    localparam longint MINV  = -32768;
    localparam int     LAT   = W + 3;
    localparam int     LAT0  = 2;
    localparam int     WDOG  = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, div_zero;
    logic signed [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic signed [W-1:0] qr, qi;

    ccdiv_seq #(.TOTAL_WIDTH(W), .FRAC_WIDTH(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qr        (qr),
        .qi        (qi),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        longint qr;
        longint qi;
        bit     dz;
        int     acc;
        int     lat;
        bit     pin;
        longint pqr;
        longint pqi;
        bit     pdz;
    } exp_t;

    exp_t exp_q[$];
    bit   prev_valid = 1'b0;

    // Literal expectations the driver attaches to the next accepted operation.
    bit     pin_on = 1'b0;
    longint pin_qr = 0, pin_qi = 0;
    bit     pin_dz = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One quotient part: truncate toward zero, then clamp to the W-bit range.
    function automatic longint part(input longint n, input longint d);
        longint m, q, r;
        m = (n < 0) ? -n : n;
        q = (m * (longint'(1) << F)) / d;
        r = (n < 0) ? -q : q;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        return r;
    endfunction

    function automatic exp_t model(input longint xr, input longint xi,
                                   input longint yr, input longint yi);
        exp_t e;
        longint nr, ni, d;
        nr = xr * yr + xi * yi;
        ni = xi * yr - xr * yi;
        d  = yr * yr + yi * yi;
        e = '{default: 0};
        if (d == 0) begin
            e.qr = 0;
            e.qi = 0;
            e.dz = 1'b1;
            e.lat = LAT0;
        end else begin
            e.qr = part(nr, d);
            e.qi = part(ni, d);
            e.dz = 1'b0;
            e.lat = LAT;
        end
        return e;
    endfunction

    task automatic check_output(input exp_t e, input bit first);
        chk("qr", qr, e.qr);
        chk("qi", qi, e.qi);
        chk("div_zero", div_zero, e.dz);
        if (e.pin) begin
            chk("pin_qr", qr, e.pqr);
            chk("pin_qi", qi, e.pqi);
            chk("pin_div_zero", div_zero, e.pdz);
        end
        if (first) chk("latency", cyc - e.acc, e.lat);
    endtask

    // Compare process: runs on every falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_valid <= 1'b0;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_qr", qr, 0);
            chk("rst_qi", qi, 0);
            chk("rst_div_zero", div_zero, 0);
        end else begin
            chk("in_ready", in_ready, (exp_q.size() == 0) ? 1 : 0);
            if (in_valid && in_ready) begin
                e = model(ar, ai, br, bi);
                e.acc = cyc + 1;
                e.pin = pin_on;
                e.pqr = pin_qr;
                e.pqi = pin_qi;
                e.pdz = pin_dz;
                exp_q.push_back(e);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    check_output(exp_q[0], !prev_valid);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > WDOG) begin
                total++;
                bad++;
                $display("[TB] FAIL result_timeout: waited %0d cycles, limit %0d", cyc - exp_q[0].acc, WDOG);
                void'(exp_q.pop_front());
            end
            prev_valid <= out_valid && !out_ready;
        end
    end

    function automatic logic signed [W-1:0] rand_op();
        case ($urandom % 8)
            0: return 16'sd0;
            1: return -16'sd32768;
            2: return 16'sd32767;
            3: return 16'sd256;
            4: return -16'sd256;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic scramble();
        ar = rand_op();
        ai = rand_op();
        br = rand_op();
        bi = rand_op();
    endtask

    // Present one operand set until accepted, then scramble the inputs.
    task automatic apply_stimulus(input logic signed [W-1:0] xr, input logic signed [W-1:0] xi,
                                  input logic signed [W-1:0] yr, input logic signed [W-1:0] yi,
                                  input bit pin, input longint eqr, input longint eqi, input bit edz);
        @(posedge clk);
        #1;
        ar = xr; ai = xi; br = yr; bi = yi;
        pin_on = pin; pin_qr = eqr; pin_qi = eqi; pin_dz = edz;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pin_on = 1'b0;
        scramble();
    endtask

    task automatic wait_result();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) break;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed operations with hand-computed results.
        apply_stimulus(512, 512, 256, 256, 1, 512, 0, 0);       wait_result();
        apply_stimulus(256, 0, 0, 256, 1, 0, -256, 0);          wait_result();
        apply_stimulus(-256, 0, 768, 0, 1, -85, 0, 0);          wait_result();
        apply_stimulus(123, -77, 0, 0, 1, 0, 0, 1);             wait_result();
        apply_stimulus(100, -100, 256, 0, 1, 100, -100, 0);     wait_result();
        apply_stimulus(25600, -25600, 1, 0, 1, 32767, -32768, 0); wait_result();
        apply_stimulus(-32768, 0, -256, 0, 1, 32767, 0, 0);     wait_result();

        // Back-pressure: hold the result for 10 cycles while in_valid pulses.
        out_ready = 1'b0;
        apply_stimulus(512, 512, 256, 256, 1, 512, 0, 0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            scramble();
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Abort mid-divide, then confirm a fresh operation runs normally.
        apply_stimulus(256, 0, 0, 256, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        apply_stimulus(-256, 0, 768, 0, 1, -85, 0, 0);          wait_result();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom % 3) == 0;
            out_ready = ($urandom % 4) != 0;
            ar = rand_op();
            ai = rand_op();
            if (($urandom % 16) == 0) begin
                br = 0;
                bi = 0;
            end else begin
                br = rand_op();
                bi = rand_op();
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (60) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccdiv_seq.md
CCDIV_SEQ -- requirements
Module: ccdiv_seq

Interface
REQ-001 SHALL have parameter TOTAL_WIDTH, default 16: signed fixed-point word width of all complex operands and results.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8: fractional bits (1.0 = 2^FRAC_WIDTH).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 ar, ai  input  TOTAL_WIDTH signed  dividend a, real and imaginary parts.
REQ-008 br, bi  input  TOTAL_WIDTH signed  divisor b, real and imaginary parts.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 qr, qi  output  TOTAL_WIDTH signed  quotient q = a/b, real and imaginary parts.
REQ-012 div_zero  output  1  b was 0+0i; valid with out_valid.

Function
REQ-013 SHALL compute q = a*conj(b)/|b|^2, the inverse of the team's pipelined complex multiplier.
- nr = ar*br + ai*bi; ni = ai*br - ar*bi.
- d = br^2 + bi^2.
- Products are full-width 2*TOTAL_WIDTH, sums carry one guard bit, and nothing is truncated before division.
REQ-014 SHALL form each part as sign(n) * floor((|n| << FRAC_WIDTH) / d), i.e. truncation toward zero.
- Both parts use a sequential restoring divider run in parallel, one quotient bit per cycle.
REQ-015 SHALL saturate each part independently: positive results at or above 2^(W-1)-1 give 2^(W-1)-1; negative results at or below -2^(W-1) give -2^(W-1). W = TOTAL_WIDTH.
REQ-016 SHALL implement an FSM with states IDLE, MULT, DIV, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready, register ar/ai/br/bi and go to MULT.
REQ-018 MULT: 1 cycle, computes nr, ni, d and the overflow pre-check; goes to DIV if d!=0, else to DONE.
REQ-019 DIV: exactly TOTAL_WIDTH+1 cycles, driven by an iteration counter, then goes to DONE.
REQ-020 DONE: out_valid=1; qr, qi, div_zero are registered and held stable until out_valid&&out_ready; then returns to IDLE.
REQ-021 in_ready SHALL be 1 only in IDLE and SHALL NOT depend combinationally on out_ready.
- One idle cycle therefore separates results.
- in_valid is ignored outside IDLE.
REQ-022 Latency: out_valid SHALL rise TOTAL_WIDTH+3 clock edges after the accepting edge when d!=0 (19 for the default), and 2 edges after it when d==0.
REQ-023 Divide-by-zero: qr=qi=0 and div_zero=1; the divider is not run.
REQ-024 div_zero SHALL be 0 for every result with d!=0.
REQ-025 Operands SHALL be captured at accept; input changes afterwards SHALL NOT affect the result in flight.
REQ-026 Most-negative operand -2^(W-1) SHALL be handled without wrap, because magnitudes are taken at widened width.

Reset
REQ-027 While rst_n=0: state IDLE, in_ready=1, out_valid=0, qr=qi=0, div_zero=0, counter and internal registers 0.
REQ-028 Assertion of rst_n mid-MULT, mid-DIV or in DONE SHALL abort the operation immediately; no result is emitted afterwards.
REQ-029 After release, the first accept behaves identically to a post-power-up accept.

Verification (TOTAL_WIDTH=16, FRAC_WIDTH=8)
REQ-030 a=(512,512), b=(256,256), out_ready=1 -> out_valid exactly 19 edges after accept; qr=512, qi=0, div_zero=0.
REQ-031 a=(256,0), b=(0,256) -> qr=0, qi=-256; a=(-256,0), b=(768,0) -> qr=-85, qi=0 (truncation toward zero).
REQ-032 b=(0,0), any a -> out_valid 2 edges after accept; qr=qi=0, div_zero=1; next op b=(256,0), a=(100,-100) -> qr=100, qi=-100, div_zero=0.
REQ-033 a=(25600,-25600), b=(1,0) -> qr=32767, qi=-32768 (saturation); a=(-32768,0), b=(-256,0) -> qr=32767.
REQ-034 out_ready=0 for 10 cycles in DONE -> out_valid, qr, qi held constant and in_ready=0; in_valid pulses are ignored; on out_ready=1 the handshake completes and in_ready=1 on the next cycle.
REQ-035 rst_n pulsed low during DIV cycle 5 -> all outputs reset at once and no out_valid follows; a fresh op then gives the correct result with nominal latency.
